conv_encoder: RTL and testbench

- Rate-1/2, constraint-length-3 (4-state) convolutional encoder with zero-tail frame termination.
- It is the transmit-side counterpart of the Viterbi decoder chain: BMU/ACS/PMU/traceback.
- Bits are accepted over a valid/ready stream and encoded 2-bit symbols are emitted over a valid/ready stream.
- At frame end the encoder appends K-1 zero tail bits so the trellis returns to S0, matching the PMU reset/start condition (S0 = 0, others = 255).

---
 rtl/viterbi_pkg.sv | 13 +
 rtl/conv_enc_branch.sv | 16 +
 rtl/conv_encoder.sv | 82 ++++++++
 tb/tb_conv_encoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: trellis constants, types and encoder FSM states shared by the
// convolutional encoder and the Viterbi decoder chain.
package viterbi_pkg;
    localparam int K          = 3;
    localparam int NUM_STATES = 4;
    localparam int TAIL_LEN   = K - 1;
    localparam int TAIL_CNT_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam logic [2:0] DEFAULT_G0 = 3'b111;
    localparam logic [2:0] DEFAULT_G1 = 3'b101;
    typedef logic [1:0] trellis_state_t;
    typedef logic [1:0] symbol_t;
    typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_fsm_t;
endpackage

// File: rtl/conv_enc_branch.sv
// conv_enc_branch: one trellis branch, (input bit, state {s1,s0}) -> (symbol, next state).
// Shared with the decoder BMU so both ends use the same branch labelling.
module conv_enc_branch
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0_POLY = DEFAULT_G0,
    parameter logic [2:0] G1_POLY = DEFAULT_G1
) (
    input  logic       b,
    input  logic [1:0] state,
    output logic [1:0] sym,
    output logic [1:0] next_state
);
    assign sym        = {^(G0_POLY & {b, state}), ^(G1_POLY & {b, state})};
    assign next_state = {b, state[1]};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, K=3 convolutional encoder with zero-tail termination
// and a single registered valid/ready output stage.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0_POLY = DEFAULT_G0,
    parameter logic [2:0] G1_POLY = DEFAULT_G1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    input  logic       bit_last_i,
    output logic       bit_ready_o,
    output logic [1:0] sym_o,
    output logic       sym_valid_o,
    output logic       sym_last_o,
    input  logic       sym_ready_i,
    output logic [1:0] state_o,
    output logic       busy_o
);
    enc_fsm_t              fsm, fsm_nxt;
    trellis_state_t        state, br_next;
    symbol_t               br_sym;
    logic [TAIL_CNT_W-1:0] tail_cnt, tail_cnt_nxt;
    logic                  ld_ok, accept, tail_load, load, enc_bit, final_tail;

    conv_enc_branch #(.G0_POLY(G0_POLY), .G1_POLY(G1_POLY)) u_branch (
        .b          (enc_bit),
        .state      (state),
        .sym        (br_sym),
        .next_state (br_next)
    );

    assign ld_ok   = !sym_valid_o || sym_ready_i;
    assign state_o = state;
    assign busy_o  = fsm != IDLE;

    always_comb begin
        bit_ready_o  = (fsm == IDLE || fsm == DATA) && ld_ok;
        accept       = bit_valid_i && bit_ready_o;
        tail_load    = (fsm == TAIL) && ld_ok;
        load         = accept || tail_load;
        enc_bit      = (fsm == TAIL) ? 1'b0 : bit_i;
        final_tail   = tail_load && (tail_cnt == TAIL_CNT_W'(TAIL_LEN - 1));
        fsm_nxt      = fsm;
        tail_cnt_nxt = tail_cnt;
        case (fsm)
            IDLE: if (accept) fsm_nxt = bit_last_i ? TAIL : DATA;
            DATA: if (accept && bit_last_i) fsm_nxt = TAIL;
            TAIL: if (tail_load) begin
                fsm_nxt      = final_tail ? IDLE : TAIL;
                tail_cnt_nxt = final_tail ? '0 : tail_cnt + 1'b1;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // The trellis state advances only together with a symbol load, so
    // backpressure freezes both in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            tail_cnt    <= '0;
            state       <= '0;
            sym_o       <= '0;
            sym_valid_o <= 1'b0;
            sym_last_o  <= 1'b0;
        end else begin
            fsm      <= fsm_nxt;
            tail_cnt <= tail_cnt_nxt;
            if (load) begin
                state       <= br_next;
                sym_o       <= br_sym;
                sym_valid_o <= 1'b1;
                sym_last_o  <= final_tail;
            end else if (sym_ready_i) begin
                sym_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed and randomized checks of conv_encoder against a
// shift-history (7,5) model and a hard-decision Viterbi decoder.
module tb_conv_encoder;
    typedef logic [2:0] sym_q_t[$];
    typedef logic       bit_q_t[$];

    logic       clk = 0, rst_n = 0;
    logic       bit_i = 0, bit_valid_i = 0, bit_last_i = 0, sym_ready_i = 1;
    logic       bit_ready_o, sym_valid_o, sym_last_o, busy_o;
    logic [1:0] sym_o, state_o;
    int         total = 0, passed = 0, cyc = 0;
    sym_q_t     got_q;
    int         got_cyc[$];

    conv_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .bit_last_i  (bit_last_i),
        .bit_ready_o (bit_ready_o),
        .sym_o       (sym_o),
        .sym_valid_o (sym_valid_o),
        .sym_last_o  (sym_last_o),
        .sym_ready_i (sym_ready_i),
        .state_o     (state_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Inputs change at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk)
        if (rst_n && sym_valid_o && sym_ready_i) begin
            got_q.push_back({sym_last_o, sym_o});
            got_cyc.push_back(cyc);
        end

    function automatic bit_q_t to_q(input logic [15:0] v, input int n);
        bit_q_t q;
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
        return q;
    endfunction

    // Code bits straight from the generator definition over the bit history.
    function automatic sym_q_t model(input bit_q_t bits);
        sym_q_t q;
        bit_q_t d;
        d.push_back(1'b0);
        d.push_back(1'b0);
        foreach (bits[i]) d.push_back(bits[i]);
        d.push_back(1'b0);
        d.push_back(1'b0);
        for (int i = 2; i < d.size(); i++)
            q.push_back({(i == d.size() - 1), d[i] ^ d[i-1] ^ d[i-2], d[i] ^ d[i-2]});
        return q;
    endfunction

    // Hard-decision Viterbi: PM start S0=0 others 255, traceback from S0.
    function automatic bit_q_t viterbi(input sym_q_t rx);
        int     pm[4], npm[4], prv[32][4], s, m, ns, n;
        logic [1:0] e;
        bit_q_t dec;
        n = (rx.size() > 32) ? 32 : rx.size();
        pm = '{0, 255, 255, 255};
        for (int t = 0; t < n; t++) begin
            npm = '{100000, 100000, 100000, 100000};
            for (int st = 0; st < 4; st++)
                for (int b = 0; b < 2; b++) begin
                    e  = 2'((((b ^ (st >> 1) ^ st) & 1) << 1) | ((b ^ st) & 1));
                    ns = (b << 1) | (st >> 1);
                    m  = pm[st] + $countones(e ^ rx[t][1:0]);
                    if (m < npm[ns]) begin
                        npm[ns]    = m;
                        prv[t][ns] = st;
                    end
                end
            pm = npm;
        end
        s = 0;
        for (int t = n - 1; t >= 0; t--) begin
            dec.push_front(1'(s >> 1));
            s = prv[t][s];
        end
        for (int i = 0; i < 2 && dec.size() > 0; i++) void'(dec.pop_back());
        return dec;
    endfunction

    task automatic drive_bits(input bit_q_t bq, input bit_q_t lq, input bit rv, input bit rr,
                              input int budget, output bit ok);
        int i = 0, t = 0;
        while (i < bq.size() && t < budget) begin
            bit_valid_i = rv ? ($urandom_range(0, 3) != 0) : 1'b1;
            bit_i       = bit_valid_i ? bq[i] : 1'($urandom);
            bit_last_i  = bit_valid_i ? lq[i] : 1'($urandom);
            sym_ready_i = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (bit_valid_i && bit_ready_o) i++;
            @(posedge clk);
            #1;
            t++;
        end
        bit_valid_i = 0;
        ok = (i == bq.size());
    endtask

    task automatic drain(input int want, input bit rr, output bit ok);
        int t = 0;
        while (got_q.size() < want && t < 400) begin
            sym_ready_i = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        sym_ready_i = 1;
        ok = got_q.size() >= want;
    endtask

    task automatic test_reset();
        bit ok;
        #2;
        total++;
        if ({sym_valid_o, sym_last_o, sym_o, state_o, busy_o} !== 7'b0)
            $display("FAIL reset_init: got %b want 0000000", {sym_valid_o, sym_last_o, sym_o, state_o, busy_o});
        else passed++;
        @(posedge clk);
        #1 rst_n = 1;
        drive_bits(to_q(16'b101, 3), to_q(16'b000, 3), 0, 0, 50, ok);
        total++;
        if (!ok || busy_o !== 1'b1) $display("FAIL reset_prefill: ok=%0b busy=%b want 1", ok, busy_o);
        else passed++;
        #2 rst_n = 0;
        #1;
        total++; if (sym_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", sym_valid_o); else passed++;
        total++; if (sym_last_o !== 1'b0) $display("FAIL reset_last: got %b want 0", sym_last_o); else passed++;
        total++; if (sym_o !== 2'b00) $display("FAIL reset_sym: got %b want 00", sym_o); else passed++;
        total++; if (state_o !== 2'b00) $display("FAIL reset_state: got %b want 00", state_o); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
        got_q.delete();
        got_cyc.delete();
        @(posedge clk);
        #1 rst_n = 1;
        sym_ready_i = 1;
        #1;
        total++; if (bit_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bit_ready_o); else passed++;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 0 || sym_valid_o !== 1'b0)
            $display("FAIL reset_residual: got %0d symbols valid=%b want 0 symbols valid=0", got_q.size(), sym_valid_o);
        else passed++;
    endtask

    task automatic test_frame();
        bit ok1, ok2, consec;
        logic [2:0] g;
        logic [2:0] e [6] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        got_q.delete();
        got_cyc.delete();
        drive_bits(to_q(16'b1011, 4), to_q(16'b0001, 4), 0, 0, 50, ok1);
        drain(6, 0, ok2);
        total++; if (!(ok1 && ok2)) $display("FAIL frame_done: bits_ok=%0b syms_ok=%0b want 1 1", ok1, ok2); else passed++;
        for (int i = 0; i < 6; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 3'bxxx;
            total++; if (g !== e[i]) $display("FAIL frame_sym%0d: got %b want %b", i, g, e[i]); else passed++;
        end
        consec = got_cyc.size() == 6;
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[0] + i) consec = 0;
        total++; if (!consec) $display("FAIL frame_consecutive: got gaps want none"); else passed++;
        total++; if (state_o !== 2'b00 || busy_o !== 1'b0) $display("FAIL frame_end: state=%b busy=%b want 00 0", state_o, busy_o); else passed++;
    endtask

    task automatic test_single_bit();
        bit ok1, ok2, ok3, ok4;
        logic [2:0] g;
        logic [2:0] e [6] = '{3'b000, 3'b000, 3'b100, 3'b011, 3'b010, 3'b111};
        got_q.delete();
        got_cyc.delete();
        drive_bits(to_q(16'b0, 1), to_q(16'b1, 1), 0, 0, 50, ok1);
        drain(3, 0, ok2);
        drive_bits(to_q(16'b1, 1), to_q(16'b1, 1), 0, 0, 50, ok3);
        drain(6, 0, ok4);
        total++; if (!(ok1 && ok2 && ok3 && ok4) || got_q.size() != 6) $display("FAIL single_count: got %0d symbols want 6", got_q.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 3'bxxx;
            total++; if (g !== e[i]) $display("FAIL single_sym%0d: got %b want %b", i, g, e[i]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2, ok3;
        logic [2:0] g;
        logic [2:0] e [6] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        got_q.delete();
        got_cyc.delete();
        drive_bits(to_q(16'b10, 2), to_q(16'b00, 2), 0, 0, 50, ok1);
        bit_valid_i = 1;
        bit_i       = 1;
        bit_last_i  = 0;
        sym_ready_i = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (sym_o !== 2'b10 || sym_valid_o !== 1'b1) $display("FAIL bp_hold%0d: sym=%b valid=%b want 10 1", k, sym_o, sym_valid_o); else passed++;
            total++; if (bit_ready_o !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", k, bit_ready_o); else passed++;
            total++; if (state_o !== 2'b01) $display("FAIL bp_state%0d: got %b want 01", k, state_o); else passed++;
            @(posedge clk);
            #1;
        end
        drive_bits(to_q(16'b11, 2), to_q(16'b01, 2), 0, 0, 50, ok2);
        drain(6, 0, ok3);
        total++; if (!(ok1 && ok2 && ok3) || got_q.size() != 6) $display("FAIL bp_count: got %0d symbols want 6", got_q.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 3'bxxx;
            total++; if (g !== e[i]) $display("FAIL bp_sym%0d: got %b want %b", i, g, e[i]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, gaps_ok;
        int lasts;
        logic [2:0] g;
        logic [2:0] e [9] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111, 3'b011, 3'b010, 3'b111};
        got_q.delete();
        got_cyc.delete();
        drive_bits(to_q(16'b10111, 5), to_q(16'b00011, 5), 0, 0, 50, ok1);
        drain(9, 0, ok2);
        total++; if (!(ok1 && ok2) || got_q.size() != 9) $display("FAIL b2b_count: got %0d symbols want 9", got_q.size()); else passed++;
        for (int i = 0; i < 9; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 3'bxxx;
            total++; if (g !== e[i]) $display("FAIL b2b_sym%0d: got %b want %b", i, g, e[i]); else passed++;
        end
        gaps_ok = got_cyc.size() == 9;
        lasts   = 0;
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] > 2) gaps_ok = 0;
        foreach (got_q[i]) if (got_q[i][2]) lasts++;
        total++; if (!gaps_ok) $display("FAIL b2b_gap: got a gap over one cycle want at most one"); else passed++;
        total++; if (lasts != 2) $display("FAIL b2b_lasts: got %0d want 2", lasts); else passed++;
    endtask

    task automatic test_random();
        bit     ok1, ok2;
        int     n, errs;
        bit_q_t bits, lasts, dec;
        sym_q_t exp;
        for (int f = 0; f < 200; f++) begin
            n = $urandom_range(1, 16);
            bits.delete();
            lasts.delete();
            for (int i = 0; i < n; i++) begin
                bits.push_back(1'($urandom));
                lasts.push_back(i == n - 1);
            end
            exp = model(bits);
            got_q.delete();
            got_cyc.delete();
            drive_bits(bits, lasts, 1, 1, 400, ok1);
            drain(n + 2, 1, ok2);
            errs = (got_q.size() == exp.size()) ? 0 : 1;
            if (errs == 0) foreach (exp[i]) if (got_q[i] !== exp[i]) errs++;
            total++;
            if (!(ok1 && ok2) || errs != 0)
                $display("FAIL rand_frame%0d: got %0d symbols %0d wrong want %0d symbols 0 wrong", f, got_q.size(), errs, exp.size());
            else passed++;
            dec  = viterbi(got_q);
            errs = (dec.size() == bits.size()) ? 0 : 1;
            if (errs == 0) foreach (bits[i]) if (dec[i] !== bits[i]) errs++;
            total++;
            if (errs != 0) $display("FAIL rand_decode%0d: got %0d bit errors want 0", f, errs);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_single_bit();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
